byter_stack: RTL and testbench
==============================

# byter_stack

Parametrised LIFO for the byter core: one generic block serves both the return-address stack (WIDTH 12) and the register stack (WIDTH 8). It generalises the existing fixed stack with configurable width and depth, an occupancy count, full/empty status, a defined simultaneous push/pop (replace-top) operation, and sticky overflow/underflow error flags. An optional wrap mode turns overflow into discard-oldest behaviour.

## Interface
- WIDTH, 12, data word width in bits (8 for the register stack)
- DEPTH, 16, number of entries; any integer ≥ 2 (not restricted to powers of two)
- CW, $clog2(DEPTH+1), derived count width; not overridden by instantiators
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately
- push  input  1  write din onto the stack this cycle
- pop  input  1  remove the top entry this cycle
- din  input  WIDTH  data to push
- clr_err  input  1  clear the sticky error flags
- dout  output  WIDTH  current top of stack; 0 when empty
- count  output  CW  number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky flag: a push was refused (or, in wrap mode, discarded the oldest entry)
- underflow  output  1  sticky flag: a pop was attempted while empty

## Operation
- Operation decode from {push, pop}: 00 NOP; 10 PUSH; 01 POP; 11 REPLACE.
- PUSH, not full: mem[top+1] ← din, count+1.
- PUSH, full: no data change; overflow ← 1. Wrap mode is covered under Configuration.
- POP, not empty: count−1. The storage cell is not cleared.
- POP, empty: no change; underflow ← 1.
- REPLACE, not empty: mem[top] ← din; count unchanged.
- REPLACE, empty: acts as PUSH (count becomes 1); no flag is set.
- REPLACE, full: overwrites top; no overflow.
- clr_err clears both flags at the next edge. If an error occurs in the same cycle, the error wins and the flag is set.
- dout = mem[top] when count > 0, else 0. It is combinational from registered state and never shows stale cells.
- Storage is indexed modulo DEPTH. Pointer arithmetic uses explicit wrap at DEPTH−1 → 0 for non-power-of-two DEPTH.

## Timing
- All state updates occur on the rising edge of clk. Inputs are sampled at that edge.
- dout, count, empty, full and the flags reflect an operation in the cycle after its edge; latency is 1.
- Back-to-back operations every cycle are legal, with no bubbles.
- Reset values: count 0, empty 1, full 0, overflow 0, underflow 0, dout 0, pointers 0. Memory contents are not reset.
- Reset asserted mid-sequence drops all entries immediately, without waiting for a clock. The first edge after deassertion behaves as from empty.
- In the same cycle, push after pop is not reordered: the REPLACE semantics above are the defined result.

## Configuration
- BYTER_STACK_WRAP_EN defined: PUSH on full writes din as the new top and discards the oldest entry. The bottom pointer advances modulo DEPTH, count stays DEPTH, and overflow ← 1.
- Undefined (default): PUSH on full is refused and the stack is unchanged; overflow ← 1.
- All other behaviour is identical in both builds.

## Structure
- The shared package byter_pkg holds:
  - the stack_op_e enum (NOP, PUSH, POP, REPLACE);
  - the default widths BYTER_PC_W = 12 and BYTER_DATA_W = 8.
- One sub-module, byter_stack_mem, is a DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port.
- The top/bottom pointers, counter and flag logic live in byter_stack.

## Test plan
- Reset, then push 0x001, 0x002, 0x003 (DEPTH 16) → count 3, dout 0x003. Three pops → dout 0x002, 0x001, then 0 with empty 1.
- Push 16 values, then push 0xABC → full 1, overflow 1, dout = 16th value (no wrap). Same test with BYTER_STACK_WRAP_EN → dout 0xABC, count 16; 16 pops return 0xABC down to the 2nd value pushed.
- Pop when empty → underflow 1, count 0. Assert clr_err together with another empty pop → underflow stays 1. clr_err alone → 0.
- Push 0x010, then push+pop with din 0x020 → count 1, dout 0x020. push+pop on an empty stack with din 0x030 → count 1, dout 0x030, no flags.
- DEPTH 5, WIDTH 8: run 7 push/pop cycles alternating across the pointer wrap → LIFO order is preserved and count never exceeds 5.
- Assert reset (0) asynchronously between edges while count is 4 → count 0, empty 1, dout 0 immediately. After release, a push of 0x55 → count 1, dout 0x55.

Source files
------------

// File: rtl/byter_pkg.sv
// Shared byter core definitions: default datapath widths and the stack operation encoding.
package byter_pkg;

  localparam int unsigned BYTER_PC_W   = 12;
  localparam int unsigned BYTER_DATA_W = 8;

  // Encoding matches the {push, pop} input pair
  typedef enum logic [1:0] {
    OpNop     = 2'b00,
    OpPop     = 2'b01,
    OpPush    = 2'b10,
    OpReplace = 2'b11
  } stack_op_e;

endpackage

// File: rtl/byter_stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module byter_stack_mem
  import byter_pkg::*;
#(
  parameter int unsigned WIDTH = BYTER_PC_W,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/byter_stack.sv
// Parametrised LIFO with occupancy count, full/empty, replace-top and sticky error flags.
// Build option BYTER_STACK_WRAP_EN: a push on full discards the oldest entry instead of being refused.
module byter_stack
  import byter_pkg::*;
#(
  parameter int unsigned WIDTH = BYTER_PC_W,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  // Explicit wrap so non-power-of-two depths never index past the last cell
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? LAST : p - AW'(1);
  endfunction

  // r_wp is the next free slot; the top entry sits one below it
  logic [AW-1:0] r_wp, r_bot;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, r_udf;

  stack_op_e        w_op;
  logic [AW-1:0]    w_top, w_waddr, w_wp_d, w_bot_d;
  logic [CW-1:0]    w_cnt_d;
  logic             w_we, w_empty, w_full, w_ovf_evt, w_udf_evt;
  logic [WIDTH-1:0] w_rdata;

  assign w_op    = stack_op_e'({push, pop});
  assign w_top   = ptr_dec(r_wp);
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_MAX);

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = r_wp;
    w_wp_d    = r_wp;
    w_bot_d   = r_bot;
    w_cnt_d   = r_cnt;
    w_ovf_evt = 1'b0;
    w_udf_evt = 1'b0;
    case (w_op)
      OpPush: begin
        if (!w_full) begin
          w_we    = 1'b1;
          w_wp_d  = ptr_inc(r_wp);
          w_cnt_d = r_cnt + CW'(1);
        end else begin
          w_ovf_evt = 1'b1;
`ifdef BYTER_STACK_WRAP_EN
          // Full means r_wp == r_bot, so this write lands on the oldest entry
          w_we    = 1'b1;
          w_wp_d  = ptr_inc(r_wp);
          w_bot_d = ptr_inc(r_bot);
`endif
        end
      end
      OpPop: begin
        if (!w_empty) begin
          w_wp_d  = w_top;
          w_cnt_d = r_cnt - CW'(1);
        end else begin
          w_udf_evt = 1'b1;
        end
      end
      OpReplace: begin
        w_we = 1'b1;
        if (w_empty) begin
          w_wp_d  = ptr_inc(r_wp);
          w_cnt_d = CW'(1);
        end else begin
          w_waddr = w_top;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_bot <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_wp  <= w_wp_d;
      r_bot <= w_bot_d;
      r_cnt <= w_cnt_d;
      // A same-cycle error beats clr_err
      r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
      r_udf <= w_udf_evt | (r_udf & ~clr_err);
    end
  end

  byter_stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .i_clk  (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(din),
    .i_raddr(w_top),
    .o_rdata(w_rdata)
  );

  assign dout      = w_empty ? '0 : w_rdata;
  assign count     = r_cnt;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_udf;

endmodule

// File: tb/tb_byter_stack.sv
// Bench for byter_stack: 16x12 directed table plus 5x8 reference-model sequence.
module tb_byter_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst16, push16, pop16, clr16;
  logic [11:0] din16, dout16;
  logic [4:0]  cnt16;
  logic        emp16, full16, ovf16, udf16;

  logic        rst5, push5, pop5, clr5;
  logic [7:0]  din5, dout5;
  logic [2:0]  cnt5;
  logic        emp5, full5, ovf5, udf5;

  byter_stack #(.WIDTH(12), .DEPTH(16)) dut16 (
    .clk(clk), .reset(rst16), .push(push16), .pop(pop16), .din(din16), .clr_err(clr16),
    .dout(dout16), .count(cnt16), .empty(emp16), .full(full16), .overflow(ovf16),
    .underflow(udf16)
  );

  byter_stack #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .reset(rst5), .push(push5), .pop(pop5), .din(din5), .clr_err(clr5),
    .dout(dout5), .count(cnt5), .empty(emp5), .full(full5), .overflow(ovf5),
    .underflow(udf5)
  );

  typedef struct {
    string name;
    int    cnt;
    int    dout;
    bit    ovf;
    bit    udf;
  } exp_t;

  typedef struct {
    bit   push;
    bit   pop;
    bit   clr;
    int   din;
    exp_t exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb16[$];
  exp_t sb5[$];
  int   n_pass  = 0;
  int   n_total = 0;

  bit [7:0] m[$];
  bit       m_ovf = 0, m_udf = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cmp(input exp_t e, input int depth, input int cnt, input int dout,
                     input bit emp, input bit full, input bit ovf, input bit udf);
    check({e.name, ".count"}, cnt, e.cnt);
    check({e.name, ".dout"}, dout, e.dout);
    check({e.name, ".empty"}, int'(emp), int'(e.cnt == 0));
    check({e.name, ".full"}, int'(full), int'(e.cnt == depth));
    check({e.name, ".overflow"}, int'(ovf), int'(e.ovf));
    check({e.name, ".underflow"}, int'(udf), int'(e.udf));
  endtask

  function automatic void add(input bit pu, input bit po, input bit cl, input int din,
                              input int cnt, input int dout, input bit ovf, input bit udf,
                              input string name);
    vec_t v;
    v.push = pu; v.pop = po; v.clr = cl; v.din = din;
    v.exp.name = name; v.exp.cnt = cnt; v.exp.dout = dout; v.exp.ovf = ovf; v.exp.udf = udf;
    vecs.push_back(v);
  endfunction

  task automatic step16(input vec_t v);
    exp_t e;
    @(negedge clk);
    push16 = v.push; pop16 = v.pop; clr16 = v.clr; din16 = v.din[11:0];
    sb16.push_back(v.exp);
    @(posedge clk);
    #1;
    push16 = 0; pop16 = 0; clr16 = 0;
    if (sb16.size() == 0) begin
      check("sb16.underrun", 1, 0);
    end else begin
      e = sb16.pop_front();
      cmp(e, 16, int'(cnt16), int'(dout16), emp16, full16, ovf16, udf16);
    end
  endtask

  task automatic step5(input bit pu, input bit po, input bit cl, input bit [7:0] d, input int i);
    exp_t e;
    bit   evo = 0, evu = 0;
    @(negedge clk);
    push5 = pu; pop5 = po; clr5 = cl; din5 = d;
    case ({pu, po})
      2'b10: begin
        if (m.size() < 5) m.push_back(d);
        else begin
          evo = 1;
`ifdef BYTER_STACK_WRAP_EN
          m.delete(0);
          m.push_back(d);
`endif
        end
      end
      2'b01: if (m.size() > 0) void'(m.pop_back()); else evu = 1;
      2'b11: if (m.size() == 0) m.push_back(d); else m[m.size()-1] = d;
      default: ;
    endcase
    m_ovf = evo | (m_ovf & !cl);
    m_udf = evu | (m_udf & !cl);
    e.name = $sformatf("d5_op%0d", i);
    e.cnt  = m.size();
    e.dout = (m.size() > 0) ? int'(m[m.size()-1]) : 0;
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    sb5.push_back(e);
    @(posedge clk);
    #1;
    push5 = 0; pop5 = 0; clr5 = 0;
    if (sb5.size() == 0) begin
      check("sb5.underrun", 1, 0);
    end else begin
      e = sb5.pop_front();
      cmp(e, 5, int'(cnt5), int'(dout5), emp5, full5, ovf5, udf5);
      check({e.name, ".bound"}, int'(cnt5 <= 3'd5), 1);
    end
  endtask

  initial begin
    int stk[16];
    rst16 = 0; push16 = 0; pop16 = 0; clr16 = 0; din16 = '0;
    rst5 = 0; push5 = 0; pop5 = 0; clr5 = 0; din5 = '0;
    #12;
    check("rst.count", int'(cnt16), 0);
    check("rst.empty", int'(emp16), 1);
    check("rst.full", int'(full16), 0);
    check("rst.dout", int'(dout16), 0);
    check("rst.flags", int'({ovf16, udf16}), 0);
    @(negedge clk);
    rst16 = 1; rst5 = 1;

    add(1, 0, 0, 'h001, 1, 'h001, 0, 0, "push1");
    add(1, 0, 0, 'h002, 2, 'h002, 0, 0, "push2");
    add(1, 0, 0, 'h003, 3, 'h003, 0, 0, "push3");
    add(0, 1, 0, 0, 2, 'h002, 0, 0, "pop1");
    add(0, 1, 0, 0, 1, 'h001, 0, 0, "pop2");
    add(0, 1, 0, 0, 0, 0, 0, 0, "pop3");
    add(0, 1, 0, 0, 0, 0, 0, 1, "pop_empty");
    add(0, 1, 1, 0, 0, 0, 0, 1, "clr_vs_err");
    add(0, 0, 1, 0, 0, 0, 0, 0, "clr_alone");
    add(1, 0, 0, 'h010, 1, 'h010, 0, 0, "push10");
    add(1, 1, 0, 'h020, 1, 'h020, 0, 0, "replace");
    add(0, 1, 0, 0, 0, 0, 0, 0, "pop_repl");
    add(1, 1, 0, 'h030, 1, 'h030, 0, 0, "replace_empty");
    add(0, 1, 0, 0, 0, 0, 0, 0, "pop_repl2");
    for (int i = 0; i < 16; i++) add(1, 0, 0, 'h101 + i, i + 1, 'h101 + i, 0, 0,
                                     $sformatf("fill%0d", i));
    add(1, 1, 0, 'h0EE, 16, 'h0EE, 0, 0, "replace_full");
`ifdef BYTER_STACK_WRAP_EN
    add(1, 0, 0, 'hABC, 16, 'hABC, 1, 0, "push_full");
    for (int i = 0; i < 14; i++) stk[i] = 'h102 + i;
    stk[14] = 'h0EE;
    stk[15] = 'hABC;
`else
    add(1, 0, 0, 'hABC, 16, 'h0EE, 1, 0, "push_full");
    for (int i = 0; i < 15; i++) stk[i] = 'h101 + i;
    stk[15] = 'h0EE;
`endif
    for (int k = 1; k <= 16; k++) add(0, 1, 0, 0, 16 - k, (k < 16) ? stk[15 - k] : 0, 1, 0,
                                      $sformatf("drain%0d", k));
    add(0, 1, 0, 0, 0, 0, 1, 1, "pop_empty2");
    add(0, 0, 1, 0, 0, 0, 0, 0, "clr2");
    add(0, 1, 0, 0, 0, 0, 0, 1, "pop_empty3");
    for (int i = 0; i < 4; i++) add(1, 0, 0, 'h201 + i, i + 1, 'h201 + i, 0, 1,
                                    $sformatf("pre_rst%0d", i));

    foreach (vecs[i]) step16(vecs[i]);

    // Asynchronous reset between edges with count 4
    @(negedge clk);
    #2;
    rst16 = 0;
    #1;
    check("arst.count", int'(cnt16), 0);
    check("arst.empty", int'(emp16), 1);
    check("arst.dout", int'(dout16), 0);
    check("arst.underflow", int'(udf16), 0);
    #1;
    rst16 = 1;
    vecs.delete();
    add(1, 0, 0, 'h055, 1, 'h055, 0, 0, "post_rst_push");
    step16(vecs[0]);

    // DEPTH 5: fill, then alternate across the pointer wrap, then random traffic
    for (int i = 0; i < 5; i++) step5(1, 0, 0, 8'(8'h10 + i), i);
    for (int i = 0; i < 7; i++) step5(i[0] == 0, i[0] == 1, 0, 8'(8'h40 + i), 5 + i);
    for (int i = 0; i < 3; i++) step5(0, 1, 0, 8'h00, 12 + i);
    for (int i = 0; i < 6; i++) step5(1, 0, 0, 8'(8'h60 + i), 15 + i);
    for (int i = 0; i < 70; i++) begin
      bit pu, po, cl;
      pu = ($urandom_range(0, 2) != 0) ^ (i >= 35);
      po = ($urandom_range(0, 2) == 0) ^ (i >= 35);
      cl = ($urandom_range(0, 9) == 0);
      step5(pu, po, cl, 8'($urandom_range(0, 255)), 21 + i);
    end
    for (int i = 0; i < 6; i++) step5(0, 1, 0, 8'h00, 91 + i);

    check("sb16.drained", sb16.size(), 0);
    check("sb5.drained", sb5.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
